// File: rtl/wb_stim_pkg.sv
// wb_stim_pkg: shared types and helpers for the Wishbone stimulus responder.
// Holds the bus FSM state enum, the default NOP word, the result record
// layout and the lane-select helper used when capturing core writes.
package wb_stim_pkg;

  // ARM "mov r0,r0": what the core fetches when no instruction is queued.
  localparam logic [31:0] NOP_WORD_DEF = 32'hE1A00000;

  // The result record carries a wide address field so any ADDR_W up to 64
  // fits; the top zero-extends on capture and truncates on output.
  localparam int REC_ADR_W  = 64;

  // The lane helper scans up to 16 byte-select nibble groups (DATA_W <= 512).
  localparam int MAX_SEL_W  = 64;
  localparam int LANE_IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    HOLD = 2'd2
  } bus_state_e;

  typedef struct packed {
    logic [REC_ADR_W-1:0] adr;
    logic [31:0]          data;
  } res_rec_t;

  // Index of the lowest 4-bit select group with any bit set; 0 if none.
  function automatic logic [LANE_IDX_W-1:0] lowestLane(input logic [MAX_SEL_W-1:0] sel);
    logic [LANE_IDX_W-1:0] lane;
    lane = '0;
    for (int i = MAX_SEL_W/4 - 1; i >= 0; i--) begin
      if (sel[4*i +: 4] != 4'b0000) begin
        lane = LANE_IDX_W'(i);
      end
    end
    return lane;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with a registered head word and an
// extra-bit occupancy counter. Pushes to a full FIFO and pops from an empty
// FIFO are ignored; push and pop in the same cycle leave occupancy unchanged.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q;
  logic [PTR_W-1:0] rdPtr_q;
  logic [PTR_W-1:0] rdNext;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] head_d;
  logic             doPush;
  logic             doPop;

  assign doPush = push_i && (count_q != CNT_W'(DEPTH));
  assign doPop  = pop_i && (count_q != '0);
  assign rdNext = rdPtr_q + PTR_W'(1);

  // Work out what the head register must show after this edge.
  always_comb begin
    head_d = head_q;
    if (doPop) begin
      if (count_q > CNT_W'(1)) begin
        head_d = mem_q[rdNext];
      end else if (doPush) begin
        head_d = push_data_i;
      end
    end else if (doPush && (count_q == '0)) begin
      head_d = push_data_i;
    end
  end

  // Storage array, left without reset so it can map onto plain registers/RAM.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= push_data_i;
    end
  end

  // Pointers, occupancy and head register; reset flushes the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else begin
      head_q <= head_d;
      if (doPush) begin
        wrPtr_q <= wrPtr_q + PTR_W'(1);
      end
      if (doPop) begin
        rdPtr_q <= rdNext;
      end
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = head_q;
  assign count_o = count_q;

endmodule

// File: rtl/wb_stim_responder.sv
// wb_stim_responder: Wishbone B3 classic slave between the stimulus driver
// and the core's Wishbone master. Core reads pop queued instruction words
// (replicated on every 32-bit lane, NOP when empty); core writes are captured
// into a result queue. A counted, registered core clock enable limits how
// many cycles the core runs per run_req.
// Optional build macro WB_STIM_ERR_INJECT_EN adds err_adr/err_arm: one armed
// access to err_adr answers with i_wb_err instead of an ack.
module wb_stim_responder
  import wb_stim_pkg::*;
#(
  parameter int          DATA_W   = 128,
  parameter int          ADDR_W   = 32,
  parameter int          IQ_DEPTH = 8,
  parameter int          RQ_DEPTH = 8,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEF,
  parameter int          CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      inst_valid,
  input  logic [31:0]               inst_data,
  output logic                      inst_ready,
  input  logic                      run_req,
  input  logic [CNT_W-1:0]          run_cycles,
  output logic                      core_ce,
  output logic                      run_busy,
  input  logic [ADDR_W-1:0]         o_wb_adr,
  input  logic [DATA_W/8-1:0]       o_wb_sel,
  input  logic                      o_wb_we,
  input  logic [DATA_W-1:0]         o_wb_dat,
  input  logic                      o_wb_cyc,
  input  logic                      o_wb_stb,
  output logic [DATA_W-1:0]         i_wb_dat,
  output logic                      i_wb_ack,
  output logic                      i_wb_err,
  output logic                      res_valid,
  output logic [31:0]               res_data,
  output logic [ADDR_W-1:0]         res_adr,
  input  logic                      res_ready,
`ifdef WB_STIM_ERR_INJECT_EN
  input  logic [ADDR_W-1:0]         err_adr,
  input  logic                      err_arm,
`endif
  output logic [$clog2(IQ_DEPTH):0] iq_count
);

  localparam int LANES  = DATA_W / 32;
  localparam int IQ_CW  = $clog2(IQ_DEPTH) + 1;
  localparam int RQ_CW  = $clog2(RQ_DEPTH) + 1;
  localparam int REC_W  = $bits(res_rec_t);

  logic [CNT_W-1:0]      budget_q;
  logic [CNT_W-1:0]      budget_d;
  logic                  ce_q;
  bus_state_e            state_q;
  bus_state_e            state_d;
  logic                  overflow_q;
  logic                  ackPhase;
  logic                  errAccess;
  logic                  ackResp;
  logic                  errResp;
  logic                  rdFire;
  logic                  wrFire;
  logic [31:0]           iqHead;
  logic [IQ_CW-1:0]      iqCount;
  logic                  iqFull;
  logic                  iqEmpty;
  logic                  instPush;
  logic                  instPop;
  logic [31:0]           rdWord;
  logic [LANE_IDX_W-1:0] wrLane;
  logic [31:0]           wrWord;
  res_rec_t              resIn;
  res_rec_t              rqHead;
  logic [RQ_CW-1:0]      rqCount;
  logic                  rqFull;
  logic                  resPush;
  logic                  resPop;

  // Next budget value: a request (re)loads, otherwise count down to zero.
  always_comb begin
    budget_d = budget_q;
    if (run_req) begin
      budget_d = run_cycles;
    end else if (budget_q != '0) begin
      budget_d = budget_q - CNT_W'(1);
    end
  end

  // Budget counter plus a registered copy of "budget nonzero" as the enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      budget_q <= '0;
      ce_q     <= 1'b0;
    end else begin
      budget_q <= budget_d;
      ce_q     <= (budget_d != '0);
    end
  end

  assign core_ce  = ce_q;
  assign run_busy = (budget_q != '0);

  // Bus FSM next state; nothing moves while the core is stalled by core_ce.
  always_comb begin
    state_d = state_q;
    if (ce_q) begin
      case (state_q)
        IDLE:    if (o_wb_cyc && o_wb_stb) state_d = ACK;
        ACK:     state_d = o_wb_stb ? HOLD : IDLE;
        HOLD:    if (!o_wb_stb) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Bus FSM state register and the sticky result-overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (wrFire && rqFull) begin
        overflow_q <= 1'b1;
      end
    end
  end

`ifdef WB_STIM_ERR_INJECT_EN
  logic armed_q;
  logic armPrev_q;
  logic errHit_q;

  // Arm on a rising err_arm, disarm after the error response; latch whether
  // the access being started targets the armed address.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed_q   <= 1'b0;
      armPrev_q <= 1'b0;
      errHit_q  <= 1'b0;
    end else begin
      armPrev_q <= err_arm;
      if (errResp) begin
        armed_q <= 1'b0;
      end
      if (err_arm && !armPrev_q) begin
        armed_q <= 1'b1;
      end
      if (state_q == IDLE) begin
        errHit_q <= armed_q && (o_wb_adr == err_adr);
      end
    end
  end

  assign errAccess = errHit_q;
`else
  assign errAccess = 1'b0;
`endif

  assign ackPhase = (state_q == ACK) && ce_q;
  assign ackResp  = ackPhase && !errAccess;
  assign errResp  = ackPhase && errAccess;
  assign rdFire   = ackResp && !o_wb_we;
  assign wrFire   = ackResp && o_wb_we;
  assign i_wb_ack = ackResp;
  assign i_wb_err = errResp;

  assign iqFull   = (iqCount == IQ_CW'(IQ_DEPTH));
  assign iqEmpty  = (iqCount == '0);
  assign instPush = inst_valid && !iqFull;
  assign instPop  = rdFire && !iqEmpty;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (IQ_DEPTH)
  ) u_inst_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (instPush),
    .push_data_i (inst_data),
    .pop_i       (instPop),
    .head_o      (iqHead),
    .count_o     (iqCount)
  );

  assign inst_ready = !iqFull;
  assign iq_count   = iqCount;
  assign rdWord     = iqEmpty ? NOP_WORD : iqHead;
  assign i_wb_dat   = rdFire ? {LANES{rdWord}} : '0;

  assign wrLane = lowestLane(MAX_SEL_W'(o_wb_sel));

  // Pick the 32-bit write lane named by the lowest active select group.
  always_comb begin
    wrWord = '0;
    for (int i = 0; i < LANES; i++) begin
      if (wrLane == LANE_IDX_W'(i)) begin
        wrWord = o_wb_dat[32*i +: 32];
      end
    end
  end

  assign resIn.adr  = REC_ADR_W'(o_wb_adr);
  assign resIn.data = wrWord;
  assign rqFull     = (rqCount == RQ_CW'(RQ_DEPTH));
  assign resPush    = wrFire && !rqFull;
  assign resPop     = res_ready && res_valid;

  sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (RQ_DEPTH)
  ) u_res_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (resPush),
    .push_data_i (resIn),
    .pop_i       (resPop),
    .head_o      (rqHead),
    .count_o     (rqCount)
  );

  assign res_valid = (rqCount != '0);
  assign res_data  = rqHead.data;
  assign res_adr   = ADDR_W'(rqHead.adr);

  // Once a write has been dropped on a full result queue the flag stays set.
  ovfSticky: assert property (@(posedge clk) disable iff (rst) overflow_q |=> overflow_q);

endmodule

// File: tb/tb_wb_stim_responder.sv
// tb_wb_stim_responder: directed + randomized bench for wb_stim_responder.
// The bench plays the core's Wishbone master and the stimulus driver, and
// keeps its own instruction/result queues to predict every response.
module tb_wb_stim_responder;

  localparam int          DATA_W   = 128;
  localparam int          ADDR_W   = 32;
  localparam int          IQ_DEPTH = 8;
  localparam int          RQ_DEPTH = 8;
  localparam int          CNT_W    = 16;
  localparam logic [31:0] NOP      = 32'hE1A00000;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      inst_valid;
  logic [31:0]               inst_data;
  logic                      inst_ready;
  logic                      run_req;
  logic [CNT_W-1:0]          run_cycles;
  logic                      core_ce;
  logic                      run_busy;
  logic [ADDR_W-1:0]         o_wb_adr;
  logic [DATA_W/8-1:0]       o_wb_sel;
  logic                      o_wb_we;
  logic [DATA_W-1:0]         o_wb_dat;
  logic                      o_wb_cyc;
  logic                      o_wb_stb;
  logic [DATA_W-1:0]         i_wb_dat;
  logic                      i_wb_ack;
  logic                      i_wb_err;
  logic                      res_valid;
  logic [31:0]               res_data;
  logic [ADDR_W-1:0]         res_adr;
  logic                      res_ready;
  logic [$clog2(IQ_DEPTH):0] iq_count;
`ifdef WB_STIM_ERR_INJECT_EN
  logic [ADDR_W-1:0]         err_adr;
  logic                      err_arm;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] instModel[$];
  logic [31:0] resDataModel[$];
  logic [31:0] resAdrModel[$];

  int           ceCount;
  int           nRand;
  int           acks;
  int           errs;
  logic [127:0] rdat;
  logic [127:0] wdat;
  logic [15:0]  sel;

  always #5 clk = ~clk;

  wb_stim_responder #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .IQ_DEPTH (IQ_DEPTH),
    .RQ_DEPTH (RQ_DEPTH),
    .NOP_WORD (NOP),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .inst_valid (inst_valid),
    .inst_data  (inst_data),
    .inst_ready (inst_ready),
    .run_req    (run_req),
    .run_cycles (run_cycles),
    .core_ce    (core_ce),
    .run_busy   (run_busy),
    .o_wb_adr   (o_wb_adr),
    .o_wb_sel   (o_wb_sel),
    .o_wb_we    (o_wb_we),
    .o_wb_dat   (o_wb_dat),
    .o_wb_cyc   (o_wb_cyc),
    .o_wb_stb   (o_wb_stb),
    .i_wb_dat   (i_wb_dat),
    .i_wb_ack   (i_wb_ack),
    .i_wb_err   (i_wb_err),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_adr    (res_adr),
    .res_ready  (res_ready),
`ifdef WB_STIM_ERR_INJECT_EN
    .err_adr    (err_adr),
    .err_arm    (err_arm),
`endif
    .iq_count   (iq_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic startRun(input int n);
    run_req    = 1'b1;
    run_cycles = CNT_W'(n);
    tick();
    run_req    = 1'b0;
  endtask

  task automatic pushInst(input logic [31:0] word);
    if (instModel.size() < IQ_DEPTH) instModel.push_back(word);
    inst_valid = 1'b1;
    inst_data  = word;
    tick();
    inst_valid = 1'b0;
  endtask

  // One core bus access; stb stays up until the cycle after the response and
  // for at least 'hold' cycles, then three quiet cycles watch for extra acks.
  task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [15:0] s,
                               input logic [127:0] d, input int hold,
                               output int nAck, output int nErr, output logic [127:0] rd);
    int n;
    int ackAt;
    bit seen;
    nAck = 0; nErr = 0; rd = '0; n = 0; ackAt = 0; seen = 0;
    o_wb_we = we; o_wb_adr = adr; o_wb_sel = s; o_wb_dat = d;
    o_wb_cyc = 1'b1; o_wb_stb = 1'b1;
    while (n < 40) begin
      tick();
      n++;
      if (i_wb_ack) begin nAck++; rd = i_wb_dat; if (!seen) ackAt = n; seen = 1; end
      if (i_wb_err) begin nErr++; if (!seen) ackAt = n; seen = 1; end
      if (seen && n > ackAt && n >= hold) break;
    end
    o_wb_cyc = 1'b0; o_wb_stb = 1'b0;
    repeat (3) begin
      tick();
      if (i_wb_ack) nAck++;
      if (i_wb_err) nErr++;
    end
    o_wb_we = 1'b0;
  endtask

  task automatic doRead(input string tag, input logic [31:0] adr, input int hold);
    int na;
    int ne;
    logic [127:0] rd;
    logic [31:0] exp;
    applyStimulus(1'b0, adr, 16'hFFFF, '0, hold, na, ne, rd);
    exp = (instModel.size() > 0) ? instModel.pop_front() : NOP;
    checkOutput({tag, " acks"}, 128'(na), 128'(1));
    checkOutput({tag, " errs"}, 128'(ne), 128'(0));
    checkOutput({tag, " data"}, rd, {4{exp}});
    checkOutput({tag, " iq_count"}, 128'(iq_count), 128'(instModel.size()));
  endtask

  task automatic doWrite(input string tag, input logic [31:0] adr, input logic [15:0] s,
                         input logic [127:0] d);
    int na;
    int ne;
    int lane;
    logic [127:0] rd;
    applyStimulus(1'b1, adr, s, d, 0, na, ne, rd);
    lane = 0;
    for (int g = 15; g >= 0; g--) if (s[4*g +: 4] != 4'b0) lane = g;
    if (resDataModel.size() < RQ_DEPTH) begin
      resDataModel.push_back(d[32*lane +: 32]);
      resAdrModel.push_back(adr);
    end
    checkOutput({tag, " acks"}, 128'(na), 128'(1));
    checkOutput({tag, " res_valid"}, 128'(res_valid), 128'(1));
  endtask

  task automatic popResult(input string tag);
    checkOutput({tag, " res_valid"}, 128'(res_valid), 128'(1));
    checkOutput({tag, " res_data"}, 128'(res_data), 128'(resDataModel.pop_front()));
    checkOutput({tag, " res_adr"}, 128'(res_adr), 128'(resAdrModel.pop_front()));
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; inst_valid = 1'b0; inst_data = '0; run_req = 1'b0; run_cycles = '0;
    o_wb_adr = '0; o_wb_sel = '0; o_wb_we = 1'b0; o_wb_dat = '0;
    o_wb_cyc = 1'b0; o_wb_stb = 1'b0; res_ready = 1'b0;
`ifdef WB_STIM_ERR_INJECT_EN
    err_adr = '0; err_arm = 1'b0;
`endif
    repeat (3) tick();

    checkOutput("reset inst_ready", 128'(inst_ready), 128'(1));
    checkOutput("reset core_ce", 128'(core_ce), 128'(0));
    checkOutput("reset run_busy", 128'(run_busy), 128'(0));
    checkOutput("reset ack", 128'(i_wb_ack), 128'(0));
    checkOutput("reset err", 128'(i_wb_err), 128'(0));
    checkOutput("reset dat", i_wb_dat, 128'(0));
    checkOutput("reset res_valid", 128'(res_valid), 128'(0));
    checkOutput("reset iq_count", 128'(iq_count), 128'(0));
    rst = 1'b0;
    tick();

    // Budget of 5 gives exactly 5 enabled cycles.
    startRun(5);
    ceCount = int'(core_ce);
    repeat (20) begin tick(); ceCount += int'(core_ce); end
    checkOutput("budget 5", 128'(ceCount), 128'(5));
    checkOutput("budget idle busy", 128'(run_busy), 128'(0));

    // Budget of 0 gives no enable at all.
    startRun(0);
    ceCount = int'(core_ce);
    repeat (10) begin tick(); ceCount += int'(core_ce); end
    checkOutput("budget 0", 128'(ceCount), 128'(0));

    // Random budget.
    nRand = int'($urandom_range(1, 40));
    startRun(nRand);
    ceCount = int'(core_ce);
    repeat (50) begin tick(); ceCount += int'(core_ce); end
    checkOutput("budget random", 128'(ceCount), 128'(nRand));

    // Restart during the third enabled cycle: 3 + 4 cycles.
    startRun(5);
    ceCount = int'(core_ce);
    tick(); ceCount += int'(core_ce);
    tick(); ceCount += int'(core_ce);
    run_req = 1'b1; run_cycles = CNT_W'(4);
    tick(); ceCount += int'(core_ce);
    run_req = 1'b0;
    repeat (20) begin tick(); ceCount += int'(core_ce); end
    checkOutput("budget restart", 128'(ceCount), 128'(7));

    // Long budget so the core runs through the bus tests.
    startRun(20000);

    pushInst(32'hE0810002);
    pushInst(32'hE0421003);
    pushInst(32'hE1A00000);
    checkOutput("iq_count after 3 pushes", 128'(iq_count), 128'(3));
    doRead("read1", 32'h0, 0);
    doRead("read2", 32'h4, 0);
    doRead("read3", 32'h8, 0);
    doRead("read empty", 32'hC, 0);

    wdat = {32'h11111111, 32'hDEADBEEF, 32'h22222222, 32'h33333333};
    doWrite("write lane2", 32'h100, 16'h0F00, wdat);
    popResult("pop lane2");
    checkOutput("res drained", 128'(res_valid), 128'(0));

    // Fill the instruction queue past full, then drain it.
    for (int i = 0; i < IQ_DEPTH + 1; i++) pushInst($urandom());
    checkOutput("iq full ready", 128'(inst_ready), 128'(0));
    checkOutput("iq full count", 128'(iq_count), 128'(IQ_DEPTH));
    for (int i = 0; i < IQ_DEPTH + 1; i++) doRead("read rand", $urandom(), 0);

    // Strobe held for four cycles still yields a single ack and pop.
    pushInst($urandom());
    pushInst($urandom());
    doRead("read hold4", 32'h10, 4);

    // Random writes, two more than the result queue holds.
    for (int i = 0; i < RQ_DEPTH + 2; i++) begin
      sel  = 16'($urandom_range(1, 65535));
      wdat = {$urandom(), $urandom(), $urandom(), $urandom()};
      doWrite("write rand", $urandom(), sel, wdat);
    end
    for (int i = 0; i < RQ_DEPTH; i++) popResult("pop rand");
    checkOutput("res empty after drain", 128'(res_valid), 128'(0));

    // Reset while an ack is showing.
    instModel.delete();
    pushInst($urandom());
    doWrite("write pre-reset", 32'h300, 16'h000F, {4{$urandom()}});
    o_wb_we = 1'b0; o_wb_adr = 32'h0; o_wb_sel = 16'hFFFF;
    o_wb_cyc = 1'b1; o_wb_stb = 1'b1;
    tick();
    checkOutput("ack before reset", 128'(i_wb_ack), 128'(1));
    rst = 1'b1;
    tick();
    checkOutput("ack after reset", 128'(i_wb_ack), 128'(0));
    checkOutput("iq after reset", 128'(iq_count), 128'(0));
    checkOutput("res after reset", 128'(res_valid), 128'(0));
    checkOutput("ce after reset", 128'(core_ce), 128'(0));
    rst = 1'b0; o_wb_cyc = 1'b0; o_wb_stb = 1'b0;
    instModel.delete(); resDataModel.delete(); resAdrModel.delete();
    tick();

`ifdef WB_STIM_ERR_INJECT_EN
    startRun(20000);
    pushInst(32'hE3A01005);
    err_adr = 32'h200; err_arm = 1'b1;
    tick();
    err_arm = 1'b0;
    applyStimulus(1'b0, 32'h200, 16'hFFFF, '0, 0, acks, errs, rdat);
    checkOutput("err hit errs", 128'(errs), 128'(1));
    checkOutput("err hit acks", 128'(acks), 128'(0));
    checkOutput("err hit no pop", 128'(iq_count), 128'(1));
    doRead("read after err", 32'h200, 0);
`else
    startRun(20000);
    applyStimulus(1'b0, 32'h200, 16'hFFFF, '0, 0, acks, errs, rdat);
    checkOutput("no-inject errs", 128'(errs), 128'(0));
    checkOutput("no-inject acks", 128'(acks), 128'(1));
    checkOutput("no-inject data", rdat, {4{NOP}});
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_stim_responder.md
Name: wb_stim_responder

Overview:
- Synthesizable Wishbone B3 classic slave that sits between the GUVM driver side and the core's Wishbone master port.
- Serves queued instruction words on core read cycles and captures core write cycles into a result queue.
- Generates a cycle-budgeted core clock enable, replacing the pseudo-clock gating with a counted, registered enable.
- Generalises the single-word, ad-hoc stimulus path to parametrised bus width, queue depths and lane selection.

Parameters:
- DATA_W, 128, Wishbone data width; multiple of 32 (32 or 128 used).
- ADDR_W, 32, Wishbone address width.
- IQ_DEPTH, 8, instruction queue depth; power of two, >= 2.
- RQ_DEPTH, 8, result queue depth; power of two, >= 2.
- NOP_WORD, 32'hE1A00000, word returned when the instruction queue is empty (ARM mov r0,r0).
- CNT_W, 16, width of the run-cycle budget counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- inst_valid  in  1  driver pushes inst_data
- inst_data  in  32  instruction word
- inst_ready  out  1  instruction queue not full
- run_req  in  1  pulse; load run_cycles into the budget counter
- run_cycles  in  CNT_W  number of enabled core cycles
- core_ce  out  1  core clock enable
- run_busy  out  1  budget counter nonzero
- o_wb_adr  in  ADDR_W  core address
- o_wb_sel  in  DATA_W/8  core byte selects
- o_wb_we  in  1  core write strobe
- o_wb_dat  in  DATA_W  core write data
- o_wb_cyc  in  1  core cycle
- o_wb_stb  in  1  core strobe
- i_wb_dat  out  DATA_W  read data to core
- i_wb_ack  out  1  acknowledge
- i_wb_err  out  1  error (0 unless the optional feature is enabled)
- res_valid  out  1  result queue not empty
- res_data  out  32  captured write word, head of the result queue
- res_adr  out  ADDR_W  captured write address, head of the result queue
- res_ready  in  1  driver pops the result queue
- iq_count  out  $clog2(IQ_DEPTH)+1  instruction queue occupancy

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: both queues empty; inst_ready=1; core_ce=0; run_busy=0; i_wb_ack=0; i_wb_err=0; i_wb_dat=0; res_valid=0; iq_count=0.
- Budget counter:
  - run_req loads run_cycles on the next edge.
  - core_ce=1 while the count is nonzero; the count decrements each cycle.
  - run_cycles=0 -> no enable.
  - run_req while busy reloads the counter (restart).
  - core_ce is registered and glitch-free.
- Bus FSM states: IDLE, ACK, HOLD.
  - IDLE -> ACK when core_ce & o_wb_cyc & o_wb_stb.
  - ACK drives i_wb_ack=1 for exactly one cycle (1-cycle latency after strobe).
  - Read in ACK: pop the instruction queue; the 32-bit word is replicated across all DATA_W/32 lanes. If the queue is empty, return NOP_WORD and do not pop.
  - Write in ACK: capture the 32-bit lane of the lowest set o_wb_sel nibble group, plus o_wb_adr, into the result queue.
  - ACK -> HOLD if stb is still high (core not yet dropped it); HOLD -> IDLE when stb falls. This prevents double-ack.
  - ACK -> IDLE if stb is low.
  - If core_ce falls mid-transaction, the FSM holds its state and the ack stays pending until core_ce returns.
- Result queue full on a write:
  - Ack is still given and the word is dropped.
  - A sticky overflow flag is held internally and exposed through SVA only.
- Simultaneous events:
  - Instruction push and pop in the same cycle: occupancy unchanged.
  - Push to a full queue: ignored (inst_ready=0).
  - Result push and pop in the same cycle: allowed.
- Queue pointers wrap modulo depth; occupancy is an extra-bit counter.
- rst mid-transaction: queues are flushed, ack drops the next cycle, the FSM returns to IDLE.

Optional Feature:
- Macro: WB_STIM_ERR_INJECT_EN.
- Defined:
  - Adds inputs err_adr[ADDR_W] and err_arm.
  - While armed, an access with o_wb_adr==err_adr responds with i_wb_err=1 instead of ack.
  - No queue pop or push occurs on that access.
  - err_arm is cleared by hardware after one hit.
- Undefined: the ports are absent and i_wb_err is tied to 0.

Decomposition:
- Package wb_stim_pkg holds:
  - bus FSM state enum (IDLE/ACK/HOLD)
  - NOP_WORD default constant
  - result record typedef {adr, data}
  - lane-select function (lowest set 4-bit sel group)
- Sub-module sync_fifo (parametrised WIDTH/DEPTH, registered outputs) is instantiated twice, once for instructions and once for results.

Test Plan:
- Push 3 instructions (E0810002, E0421003, E1A00000); run_req with run_cycles=10; core reads 3 times -> each ack carries the word replicated across 4 lanes; iq_count 3->0.
- Read with the queue empty -> i_wb_dat lanes = E1A00000, one ack, iq_count stays 0.
- Core writes DEADBEEF to lane 2 (sel=16'h0F00) at adr 0x100 -> res_data=DEADBEEF, res_adr=0x100, res_valid=1 one cycle after ack.
- Budget check:
  - run_cycles=5 -> core_ce high for exactly 5 cycles.
  - run_req at cycle 3 with 4 -> core_ce high for 7 cycles total.
- Stb held 4 cycles -> exactly one ack; rst asserted during ACK -> ack low the next cycle and queues empty.
- Error injection: WB_STIM_ERR_INJECT_EN with err_adr=0x200 armed -> i_wb_err=1 once, no pop; a second access to 0x200 gets a normal ack.
